// File: rtl/fan_pwm_decoder.sv
// fan_pwm_decoder: measures period and high time of a fan PWM line in
// units of enabled samples (clk_en_i high), with saturation-based timeout.
// Optional build macro FAN_PWM_DECODER_GLITCH_FILTER_EN adds a 3-sample
// majority filter between the synchronizer and the edge detector.
`timescale 1ns/1ps
module fan_pwm_decoder #(
    parameter int COUNTER_BITWIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clk_en_i,
    input  logic                      PWM_pin_i,
    output logic [COUNTER_BITWIDTH:0] periodCounterValue_o,
    output logic [COUNTER_BITWIDTH:0] highCounterValue_o,
    output logic                      valid_o,
    output logic                      timeout_o
);

    localparam int W = COUNTER_BITWIDTH + 1;
    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   high_cnt_q, high_cnt_d;
    logic [W-1:0]   period_d, high_d;
    logic           valid_d, timeout_d;
    logic [W-1:0]   nxt;
    logic           sync_p0, sync_p1;
    logic           smp, prev_smp;
    logic           rise, fall;

    // Counter increment that sticks at MAX instead of wrapping.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == MAX) ? MAX : v + ONE;
    endfunction

    // ---- stage p0/p1: two-flop synchronizer, runs every clock ----
    // Bring the asynchronous PWM line into the clk_i domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= PWM_pin_i;
            sync_p1 <= sync_p0;
        end
    end

`ifdef FAN_PWM_DECODER_GLITCH_FILTER_EN
    // ---- stage p2: majority filter history over enabled samples ----
    logic [2:0] filt_hist_p2;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

    // Shift the synchronized level into the 3-sample history on enabled samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_hist_p2 <= 3'b000;
        end else if (clk_en_i) begin
            filt_hist_p2 <= {filt_hist_p2[1:0], sync_p1};
        end
    end

    assign smp = maj3(filt_hist_p2);
`else
    assign smp = sync_p1;
`endif

    // Remember the previous enabled sample for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_smp <= 1'b0;
        end else if (clk_en_i) begin
            prev_smp <= smp;
        end
    end

    assign rise = clk_en_i &  smp & ~prev_smp;
    assign fall = clk_en_i & ~smp &  prev_smp;
    assign nxt  = sat_inc(cnt_q);

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter and measurement decisions for the current sample.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_cnt_d = high_cnt_q;
        period_d   = periodCounterValue_o;
        high_d     = highCounterValue_o;
        valid_d    = 1'b0;
        timeout_d  = timeout_o;
        if (clk_en_i) begin
            case (state_q)
                IDLE: begin
                    // No previous edge to measure from: only arm on a rising edge.
                    if (rise) begin
                        cnt_d   = ONE;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        high_cnt_d = cnt_q;
                        cnt_d      = nxt;
                        state_d    = LOW;
                    end else if (nxt == MAX) begin
                        period_d  = MAX;
                        high_d    = MAX;
                        valid_d   = 1'b1;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = nxt;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        high_d    = high_cnt_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = ONE;
                        state_d   = HIGH;
                    end else if (nxt == MAX) begin
                        period_d  = MAX;
                        high_d    = '0;
                        valid_d   = 1'b1;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = nxt;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Register counters and the published measurement; valid_o is a 1-cycle pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q                <= '0;
            high_cnt_q           <= '0;
            periodCounterValue_o <= '0;
            highCounterValue_o   <= '0;
            valid_o              <= 1'b0;
            timeout_o            <= 1'b0;
        end else begin
            cnt_q                <= cnt_d;
            high_cnt_q           <= high_cnt_d;
            periodCounterValue_o <= period_d;
            highCounterValue_o   <= high_d;
            valid_o              <= valid_d;
            timeout_o            <= timeout_d;
        end
    end

endmodule

// File: tb/tb_fan_pwm_decoder.sv
// Testbench for fan_pwm_decoder: table-driven PWM patterns, hand-written
// timeout/reset/glitch/hold sequences, and randomized segment streams
// checked against a segment-level measurement model.
`timescale 1ns/1ps
module tb_fan_pwm_decoder;

    localparam int CBW  = 8;
    localparam int MAXV = 511;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           clk_en_i;
    logic           PWM_pin_i;
    logic [CBW:0]   period_w;
    logic [CBW:0]   high_w;
    logic           valid_w;
    logic           timeout_w;

    always #5 clk_i = ~clk_i;

    fan_pwm_decoder #(.COUNTER_BITWIDTH(CBW)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .clk_en_i             (clk_en_i),
        .PWM_pin_i            (PWM_pin_i),
        .periodCounterValue_o (period_w),
        .highCounterValue_o   (high_w),
        .valid_o              (valid_w),
        .timeout_o            (timeout_w)
    );

    typedef struct { int period; int high; int to; } ev_t;
    typedef struct { int h; int l; int nper; int div; int exp_n; int exp_period; int exp_high; int exp_to; } vec_t;

    ev_t  evq[$];
    ev_t  expq[$];
    ev_t  mon_e;
    vec_t tbl[7];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   vld_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push_exp(input int p, input int h, input int t);
        ev_t e;
        e.period = p; e.high = h; e.to = t;
        expq.push_back(e);
    endtask

    // Capture every valid pulse and confirm it lasts a single clock.
    always @(negedge clk_i) begin
        if (valid_w) begin
            chk("valid_width", int'(vld_prev), 0);
            mon_e.period = int'(period_w);
            mon_e.high   = int'(high_w);
            mon_e.to     = int'(timeout_w);
            evq.push_back(mon_e);
        end
        vld_prev = valid_w;
    end

    task automatic do_reset();
        rst_i = 1'b1; clk_en_i = 1'b0; PWM_pin_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        evq.delete();
        expq.delete();
    endtask

    // Hold the pin at lvl for n enabled samples, one enable every div clocks.
    task automatic drive(input logic lvl, input int n, input int div);
        for (int i = 0; i < n; i++) begin
            PWM_pin_i = lvl;
            for (int d = 0; d < div; d++) begin
                clk_en_i = (d == div - 1);
                @(negedge clk_i);
            end
        end
        clk_en_i = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk_i);
    endtask

    task automatic cmp_events(input string tag);
        int n;
        chk({tag, "_count"}, evq.size(), expq.size());
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_period"},  evq[i].period, expq[i].period);
            chk({tag, "_high"},    evq[i].high,   expq[i].high);
            chk({tag, "_timeout"}, evq[i].to,     expq[i].to);
        end
        evq.delete();
        expq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs[5];
        int ls[5];
        int div;
        int armed;

        tbl[0] = '{64,  192, 2, 1, 2, 256, 64,  0};
        tbl[1] = '{40,  60,  2, 4, 2, 100, 40,  0};
        tbl[2] = '{2,   3,   3, 1, 3, 5,   2,   0};
        tbl[3] = '{300, 200, 2, 1, 2, 500, 300, 0};
        tbl[4] = '{100, 450, 2, 1, 2, 511, 0,   1};
        tbl[5] = '{255, 255, 2, 2, 2, 510, 255, 0};
        tbl[6] = '{256, 255, 2, 1, 2, 511, 0,   1};

        // Reset state while reset is held.
        rst_i = 1'b1; clk_en_i = 1'b0; PWM_pin_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_period",  int'(period_w),  0);
        chk("rst_high",    int'(high_w),    0);
        chk("rst_valid",   int'(valid_w),   0);
        chk("rst_timeout", int'(timeout_w), 0);

        // Table-driven PWM patterns.
        for (int r = 0; r < 7; r++) begin
            do_reset();
            for (int p = 0; p < tbl[r].nper; p++) begin
                drive(1'b1, tbl[r].h, tbl[r].div);
                drive(1'b0, tbl[r].l, tbl[r].div);
            end
            drive(1'b1, 6, tbl[r].div);
            settle();
            for (int k = 0; k < tbl[r].exp_n; k++)
                push_exp(tbl[r].exp_period, tbl[r].exp_high, tbl[r].exp_to);
            cmp_events($sformatf("row%0d", r));
        end

        // Stuck high: timeout, then a later full period clears it.
        do_reset();
        drive(1'b1, 520, 1);
        drive(1'b0, 50, 1);
        chk("to_high_flag", int'(timeout_w), 1);
        drive(1'b1, 30, 1);
        drive(1'b0, 30, 1);
        drive(1'b1, 6, 1);
        settle();
        push_exp(MAXV, MAXV, 1);
        push_exp(60, 30, 0);
        cmp_events("to_high");
        chk("to_high_cleared", int'(timeout_w), 0);

        // Stuck low after one full period.
        do_reset();
        drive(1'b1, 20, 1);
        drive(1'b0, 20, 1);
        drive(1'b1, 20, 1);
        drive(1'b0, 600, 1);
        drive(1'b1, 6, 1);
        settle();
        push_exp(40, 20, 0);
        push_exp(MAXV, 0, 1);
        cmp_events("to_low");
        chk("to_low_flag", int'(timeout_w), 1);

        // Asynchronous reset in the middle of a high phase.
        do_reset();
        drive(1'b1, 20, 1);
        drive(1'b0, 20, 1);
        drive(1'b1, 10, 1);
        chk("pre_rst_period", int'(period_w), 40);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_period",  int'(period_w),  0);
        chk("async_rst_high",    int'(high_w),    0);
        chk("async_rst_valid",   int'(valid_w),   0);
        chk("async_rst_timeout", int'(timeout_w), 0);
        PWM_pin_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        evq.delete();
        drive(1'b0, 5, 1);
        drive(1'b1, 15, 1);
        drive(1'b0, 15, 1);
        drive(1'b1, 6, 1);
        settle();
        push_exp(30, 15, 0);
        cmp_events("after_rst");

        // One-sample low glitch inside a 50-sample high phase.
        do_reset();
        drive(1'b1, 25, 1);
        drive(1'b0, 1, 1);
        drive(1'b1, 24, 1);
        drive(1'b0, 50, 1);
        drive(1'b1, 6, 1);
        settle();
`ifdef FAN_PWM_DECODER_GLITCH_FILTER_EN
        push_exp(100, 50, 0);
`else
        push_exp(26, 25, 0);
        push_exp(74, 24, 0);
`endif
        cmp_events("glitch");

        // Enable held low: pin activity must not disturb anything.
        for (int i = 0; i < 600; i++) begin
            PWM_pin_i = (i % 32) >= 16;
            @(negedge clk_i);
        end
        chk("hold_events", evq.size(), 0);
        chk("hold_timeout", int'(timeout_w), 0);
`ifdef FAN_PWM_DECODER_GLITCH_FILTER_EN
        chk("hold_period", int'(period_w), 100);
        chk("hold_high",   int'(high_w),   50);
`else
        chk("hold_period", int'(period_w), 74);
        chk("hold_high",   int'(high_w),   24);
`endif

        // Random segment streams against the segment-level model.
        for (int run = 0; run < 3; run++) begin
            do_reset();
            div = $urandom_range(1, 2);
            for (int s = 0; s < 5; s++) begin
                hs[s] = ($urandom_range(0, 5) == 0) ? $urandom_range(520, 600) : $urandom_range(2, 300);
                ls[s] = $urandom_range(2, 300);
                drive(1'b1, hs[s], div);
                drive(1'b0, ls[s], div);
            end
            drive(1'b1, 6, div);
            settle();
            armed = 0;
            for (int s = 0; s < 5; s++) begin
                if (armed != 0) push_exp(hs[s-1] + ls[s-1], hs[s-1], 0);
                if (hs[s] >= MAXV) begin
                    push_exp(MAXV, MAXV, 1);
                    armed = 0;
                end else if (hs[s] + ls[s] >= MAXV) begin
                    push_exp(MAXV, 0, 1);
                    armed = 0;
                end else begin
                    armed = 1;
                end
            end
            if (armed != 0) push_exp(hs[4] + ls[4], hs[4], 0);
            cmp_events($sformatf("rand%0d", run));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
